alu_pipe: RTL and testbench



---
 rtl/alu_pipe.sv | 186 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked WIDTH-bit ALU with a registered result and {Z,N,C,V} status.
// LSL/ASR run iteratively, one bit per cycle, in a small IDLE/SHIFT FSM.
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] val_A,
  input  logic [WIDTH-1:0] val_B,
  input  logic [2:0]       ALU_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_out,
  output logic [3:0]       flags
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOTB = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_LSL  = 3'b110;
  localparam logic [2:0] OP_ASR  = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state, state_next;

  logic signed [WIDTH-1:0] work_p1;
  logic [SW-1:0]           count_p1;
  logic                    asr_p1;

  logic                    accept;
  logic                    is_shift;
  logic                    start_shift;
  logic [SW-1:0]           shamt;
  logic                    load;
  logic [WIDTH-1:0]        load_res;
  logic [3:0]              load_flags;
  logic signed [WIDTH-1:0] step_res;
  logic                    step_c;

  function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r,
                                            input logic c,
                                            input logic v);
    return {(r == '0), r[WIDTH-1], c, v};
  endfunction

  // Returns {V, C, sum} for a + b + cin; V uses the operand/result sign rule.
  function automatic logic [WIDTH+1:0] add_full(input logic signed [WIDTH-1:0] a,
                                                input logic signed [WIDTH-1:0] b,
                                                input logic cin);
    logic [WIDTH:0] sum;
    logic           v;
    sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    return {v, sum};
  endfunction

  // Single-cycle operations; shifts only reach here with a zero amount.
  function automatic logic [WIDTH+3:0] alu_eval(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH+1:0] s;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
    s = '0;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        s = add_full(a, b, 1'b0);
        r = s[WIDTH-1:0];
        c = s[WIDTH];
        v = s[WIDTH+1];
      end
      OP_SUB: begin
        s = add_full(a, ~b, 1'b1);
        r = s[WIDTH-1:0];
        c = s[WIDTH];
        v = s[WIDTH+1];
      end
      OP_AND:  r = a & b;
      OP_NOTB: r = ~b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = a;
    endcase
    return {pack_flags(r, c, v), r};
  endfunction

  // One-bit shift; returns {bit shifted out, shifted value}.
  function automatic logic [WIDTH:0] shift_step(input logic signed [WIDTH-1:0] w,
                                                input logic asr);
    if (asr) begin
      return {w[0], w >>> 1};
    end
    return {w[WIDTH-1], w << 1};
  endfunction

  assign shamt       = val_B[SW-1:0];
  assign is_shift    = (ALU_op == OP_LSL) || (ALU_op == OP_ASR);
  assign in_ready    = (state == IDLE) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign start_shift = accept && is_shift && (shamt != '0);

  assign {step_c, step_res} = shift_step(work_p1, asr_p1);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_res   = '0;
    load_flags = '0;
    case (state)
      IDLE: begin
        if (start_shift) begin
          state_next = SHIFT;
        end else if (accept) begin
          load                   = 1'b1;
          {load_flags, load_res} = alu_eval(ALU_op, val_A, val_B);
        end
      end
      SHIFT: begin
        // Final step lands straight into the result register.
        if (count_p1 == SW'(1)) begin
          state_next = IDLE;
          load       = 1'b1;
          load_res   = step_res;
          load_flags = pack_flags(step_res, step_c, 1'b0);
        end
      end
    endcase
  end

  // Stage boundary: control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      count_p1  <= '0;
      asr_p1    <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (start_shift) begin
        count_p1 <= shamt;
        asr_p1   <= ALU_op[0];
      end else if (state == SHIFT) begin
        count_p1 <= count_p1 - SW'(1);
      end
    end
  end

  // Stage boundary: result, status and shift work register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALU_out <= '0;
      flags   <= '0;
      work_p1 <= '0;
    end else begin
      if (load) begin
        ALU_out <= load_res;
        flags   <= load_flags;
      end
      if (start_shift) begin
        work_p1 <= val_A;
      end else if (state == SHIFT) begin
        work_p1 <= step_res;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed literal cases plus randomized traffic checked
// every cycle against a cycle-counting arithmetic reference model.
module tb_alu_pipe;
  localparam int W  = 16;
  localparam int SW = 4;

  logic         clk;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] val_A = '0;
  logic [W-1:0] val_B = '0;
  logic [2:0]   ALU_op = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] ALU_out;
  logic [3:0]   flags;

  int n_tests = 0;
  int n_fail  = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .val_A     (val_A),
    .val_B     (val_B),
    .ALU_op    (ALU_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALU_out   (ALU_out),
    .flags     (flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operation definitions.
  function automatic void ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, output logic [W-1:0] r,
                                 output logic [3:0] f);
    int ua, ub, sa, sb, s, t;
    logic c, v;
    logic signed [W-1:0] as;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = int'(b[SW-1:0]);
    as = a;
    c  = 1'b0;
    v  = 1'b0;
    r  = '0;
    case (op)
      3'd0: begin
        t = ua + ub;
        r = W'(t);
        c = (t >= (1 << W));
        v = (sa + sb > (1 << (W-1)) - 1) || (sa + sb < -(1 << (W-1)));
      end
      3'd1: begin
        t = ua - ub;
        r = W'(t);
        c = (ua >= ub);
        v = (sa - sb > (1 << (W-1)) - 1) || (sa - sb < -(1 << (W-1)));
      end
      3'd2: r = a & b;
      3'd3: r = ~b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: begin
        r = a << s;
        c = (s == 0) ? 1'b0 : a[W-s];
      end
      default: begin
        r = as >>> s;
        c = (s == 0) ? 1'b0 : a[s-1];
      end
    endcase
    f = {(r == '0), r[W-1], c, v};
  endfunction

  // Model state: visible result register plus at most one shift in flight,
  // due at a fixed edge number.
  logic         m_valid = 1'b0;
  logic [W-1:0] m_out = '0;
  logic [3:0]   m_flags = '0;
  bit           pend = 1'b0;
  int           pend_due = 0;
  logic [W-1:0] pend_res = '0;
  logic [3:0]   pend_flags = '0;
  int           edge_cnt = 0;
  bit           m_rdy, m_acc;
  logic [W-1:0] m_r;
  logic [3:0]   m_f;
  int           m_s;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_valid = 1'b0;
      m_out   = '0;
      m_flags = '0;
      pend    = 1'b0;
    end else begin
      edge_cnt++;
      m_rdy = !pend && (!m_valid || out_ready);
      m_acc = in_valid && m_rdy;
      if (m_valid && out_ready) m_valid = 1'b0;
      if (pend && edge_cnt == pend_due) begin
        pend    = 1'b0;
        m_valid = 1'b1;
        m_out   = pend_res;
        m_flags = pend_flags;
      end
      if (m_acc) begin
        ref_op(ALU_op, val_A, val_B, m_r, m_f);
        m_s = int'(val_B[SW-1:0]);
        if (ALU_op[2:1] == 2'b11 && m_s != 0) begin
          pend       = 1'b1;
          pend_due   = edge_cnt + m_s;
          pend_res   = m_r;
          pend_flags = m_f;
        end else begin
          m_valid = 1'b1;
          m_out   = m_r;
          m_flags = m_f;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) chk("cmp_in_ready", in_ready, !pend && (!m_valid || out_ready));
    chk("cmp_out_valid", out_valid, m_valid);
    chk("cmp_ALU_out", ALU_out, m_out);
    chk("cmp_flags", flags, m_flags);
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n      = 0;
    ALU_op = op;
    val_A  = a;
    val_B  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("accept_wait", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic expect_result(input string name, input logic [W-1:0] er,
                               input logic [3:0] ef, input int lat);
    int n;
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      chk({name, "_in_ready_low"}, in_ready, 1'b0);
      n++;
      @(negedge clk);
    end
    chk({name, "_latency"}, n, lat);
    chk({name, "_out"}, ALU_out, er);
    chk({name, "_flags"}, flags, ef);
  endtask

  task automatic op_check(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] er,
                          input logic [3:0] ef, input int lat);
    send(op, a, b);
    expect_result(name, er, ef, lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  logic [W-1:0] tr;
  logic [3:0]   tf;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_ALU_out", ALU_out, 16'h0000);
    chk("rst_flags", flags, 4'b0000);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);

    ref_op(3'd0, 16'd37, 16'hFFFB, tr, tf);
    chk("model_add", {tf, tr}, {4'b0010, 16'd32});
    ref_op(3'd1, 16'h8000, 16'h0001, tr, tf);
    chk("model_sub", {tf, tr}, {4'b0011, 16'h7FFF});
    ref_op(3'd7, 16'h8000, 16'd15, tr, tf);
    chk("model_asr", {tf, tr}, {4'b0100, 16'hFFFF});
    ref_op(3'd6, 16'h8001, 16'd1, tr, tf);
    chk("model_lsl", {tf, tr}, {4'b0010, 16'h0002});

    @(posedge clk);
    #1;
    op_check("add_neg",   3'd0, 16'd37,   16'hFFFB, 16'd32,   4'b0010, 1);
    op_check("and_zero",  3'd2, 16'hFF00, 16'h00FF, 16'h0000, 4'b1000, 1);
    op_check("notb_ffff", 3'd3, 16'h1234, 16'hFFFF, 16'h0000, 4'b1000, 1);
    op_check("notb_4",    3'd3, 16'h1234, 16'h0004, 16'hFFFB, 4'b0100, 1);
    op_check("add_ovf",   3'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1);
    op_check("sub_ovf",   3'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011, 1);
    op_check("sub_zero",  3'd1, 16'h0000, 16'h0000, 16'h0000, 4'b1010, 1);
    op_check("lsl_4",     3'd6, 16'h0001, 16'd4,    16'h0010, 4'b0000, 5);
    op_check("asr_15",    3'd7, 16'h8000, 16'd15,   16'hFFFF, 4'b0100, 16);
    op_check("lsl_1",     3'd6, 16'h8001, 16'd1,    16'h0002, 4'b0010, 2);
    op_check("lsl_s0",    3'd6, 16'h1234, 16'h0010, 16'h1234, 4'b0000, 1);

    // Backpressure with a queued XOR
    out_ready = 1'b0;
    send(3'd0, 16'hFFFF, 16'h0004);
    expect_result("bp_add", 16'h0003, 4'b0010, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        ALU_op   = 3'd5;
        val_A    = 16'h00FF;
        val_B    = 16'h0F0F;
        in_valid = 1'b1;
      end
      @(negedge clk);
      chk("bp_hold_out", ALU_out, 16'h0003);
      chk("bp_hold_flags", flags, 4'b0010);
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1'b1);
    chk("bp_release_out", ALU_out, 16'h0003);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_xor_valid", out_valid, 1'b1);
    chk("bp_xor_out", ALU_out, 16'h0FF0);
    chk("bp_xor_flags", flags, 4'b0000);

    // Four back-to-back ADDs
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      ALU_op   = 3'd0;
      val_A    = 16'(1000 * (i + 1));
      val_B    = 16'(i + 3);
      in_valid = 1'b1;
      @(negedge clk);
      chk("b2b_in_ready", in_ready, 1'b1);
      if (i > 0) begin
        chk("b2b_valid", out_valid, 1'b1);
        chk("b2b_out", ALU_out, 16'(1000 * i + i + 2));
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid", out_valid, 1'b1);
    chk("b2b_out", ALU_out, 16'd4006);

    // Reset in the middle of a long shift
    @(posedge clk);
    #1;
    send(3'd6, 16'h0001, 16'd10);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_ALU_out", ALU_out, 16'h0000);
    chk("mid_rst_flags", flags, 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_result", out_valid, 1'b0);
      if (i == 0) chk("post_rst_in_ready", in_ready, 1'b1);
    end
    @(posedge clk);
    #1;
    op_check("post_rst_add", 3'd0, 16'd5, 16'd6, 16'd11, 4'b0000, 1);

    // Randomized traffic; the per-cycle compare does the checking
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst       = (i % 1000 == 700);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 4) != 0);
      ALU_op    = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       val_A = 16'h7FFF;
        1:       val_A = 16'h8000;
        2:       val_A = 16'hFFFF;
        default: val_A = 16'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       val_B = 16'h0001;
        1:       val_B = 16'h8000;
        2:       val_B = 16'($urandom_range(0, 3));
        default: val_B = 16'($urandom);
      endcase
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
